// File: rtl/noc_pipeline_link.sv
// Credit-based link stage: NUM_PIPELINE register stages on the flit path and on the
// credit path, plus a monitor for credit accounting, wormhole dest consistency and counts.
module noc_pipeline_link #(
    parameter int unsigned NUM_PIPELINE     = 1,
    parameter int unsigned FLIT_WIDTH       = 32,
    parameter int unsigned DEST_WIDTH       = 6,
    parameter int unsigned DOWNSTREAM_DEPTH = 1,
    parameter int unsigned CNT_WIDTH        = 16
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [FLIT_WIDTH-1:0]                   data_in,
    input  logic [DEST_WIDTH-1:0]                   dest_in,
    input  logic                                    is_tail_in,
    input  logic                                    send_in,
    output logic                                    credit_out,
    output logic [FLIT_WIDTH-1:0]                   data_out,
    output logic [DEST_WIDTH-1:0]                   dest_out,
    output logic                                    is_tail_out,
    output logic                                    send_out,
    input  logic                                    credit_in,
    input  logic                                    err_clear,
    output logic [$clog2(DOWNSTREAM_DEPTH+1)-1:0]   in_flight,
    output logic [CNT_WIDTH-1:0]                    flit_count,
    output logic [CNT_WIDTH-1:0]                    pkt_count,
    output logic [2:0]                              err
);

    localparam int unsigned IF_W = $clog2(DOWNSTREAM_DEPTH + 1);
    localparam logic [IF_W-1:0] DEPTH_V = IF_W'(DOWNSTREAM_DEPTH);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    state_t                state_q;
    logic [DEST_WIDTH-1:0] head_dest_q;
    logic [IF_W-1:0]       in_flight_nxt;
    logic                  ovf_evt;
    logic                  unf_evt;
    logic                  dest_evt;

    generate
        if (NUM_PIPELINE == 0) begin : g_bypass
            assign send_out    = send_in;
            assign data_out    = data_in;
            assign dest_out    = dest_in;
            assign is_tail_out = is_tail_in;
            assign credit_out  = credit_in;
        end else begin : g_pipe
            logic [NUM_PIPELINE-1:0] vld_q;
            logic [NUM_PIPELINE-1:0] tail_q;
            logic [NUM_PIPELINE-1:0] crd_q;
            logic [FLIT_WIDTH-1:0]   data_q [NUM_PIPELINE];
            logic [DEST_WIDTH-1:0]   dest_q [NUM_PIPELINE];

            // Forward flit chain and reverse credit chain; no stall, credits guarantee space.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_q  <= '0;
                    tail_q <= '0;
                    crd_q  <= '0;
                    for (int i = 0; i < int'(NUM_PIPELINE); i++) begin
                        data_q[i] <= '0;
                        dest_q[i] <= '0;
                    end
                end else begin
                    vld_q[0]  <= send_in;
                    tail_q[0] <= is_tail_in;
                    crd_q[0]  <= credit_in;
                    data_q[0] <= data_in;
                    dest_q[0] <= dest_in;
                    for (int i = 1; i < int'(NUM_PIPELINE); i++) begin
                        vld_q[i]  <= vld_q[i-1];
                        tail_q[i] <= tail_q[i-1];
                        crd_q[i]  <= crd_q[i-1];
                        data_q[i] <= data_q[i-1];
                        dest_q[i] <= dest_q[i-1];
                    end
                end
            end

            assign send_out    = vld_q[NUM_PIPELINE-1];
            assign is_tail_out = tail_q[NUM_PIPELINE-1];
            assign credit_out  = crd_q[NUM_PIPELINE-1];
            assign data_out    = data_q[NUM_PIPELINE-1];
            assign dest_out    = dest_q[NUM_PIPELINE-1];
        end
    endgenerate

    // Credit accounting at the upstream side; saturates on overflow, holds at 0 on underflow.
    always_comb begin
        in_flight_nxt = in_flight;
        ovf_evt       = 1'b0;
        unf_evt       = 1'b0;
        case ({send_in, credit_out})
            2'b10: begin
                if (in_flight == DEPTH_V) ovf_evt = 1'b1;
                else                      in_flight_nxt = in_flight + IF_W'(1);
            end
            2'b01: begin
                if (in_flight == '0) unf_evt = 1'b1;
                else                 in_flight_nxt = in_flight - IF_W'(1);
            end
            2'b11: begin
                if (in_flight == '0) unf_evt = 1'b1;
            end
            default: ;
        endcase
        dest_evt = (state_q == IN_PKT) && send_in && (dest_in != head_dest_q);
    end

    // Packet FSM, counters and sticky errors (a new event beats err_clear).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            head_dest_q <= '0;
            in_flight   <= '0;
            flit_count  <= '0;
            pkt_count   <= '0;
            err         <= '0;
        end else begin
            in_flight <= in_flight_nxt;
            err       <= (err & {3{~err_clear}}) | {dest_evt, unf_evt, ovf_evt};
            if (send_in) begin
                flit_count <= flit_count + CNT_WIDTH'(1);
                if (is_tail_in) pkt_count <= pkt_count + CNT_WIDTH'(1);
            end
            case (state_q)
                IDLE: begin
                    if (send_in && !is_tail_in) begin
                        state_q     <= IN_PKT;
                        head_dest_q <= dest_in;
                    end
                end
                IN_PKT: begin
                    if (send_in && is_tail_in) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_pipeline_link.sv
// Bench for noc_pipeline_link: three instances (2/3/0 stages) share stimulus; a scoreboard
// checks flit and credit timing, directed steps check the monitor outputs.
module tb_noc_pipeline_link;

    localparam int unsigned FW = 32;
    localparam int unsigned DW = 6;
    localparam int unsigned CW = 16;

    typedef struct packed {
        int            due;
        logic [FW-1:0] data;
        logic [DW-1:0] dest;
        logic          tail;
    } flit_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [FW-1:0] data_in;
    logic [DW-1:0] dest_in;
    logic          is_tail_in;
    logic          send_in;
    logic          credit_in;
    logic          err_clear;

    logic          so  [3];
    logic          co  [3];
    logic          to  [3];
    logic [FW-1:0] dout[3];
    logic [DW-1:0] deo [3];
    logic [CW-1:0] fc  [3];
    logic [CW-1:0] pc  [3];
    logic [2:0]    er  [3];
    logic [1:0]    if_p2;
    logic [2:0]    if_p3;
    logic [2:0]    if_p0;

    int    cyc;
    int    checks;
    int    failures;
    bit    sb_on;
    flit_t fq[3][$];
    int    cq[3][$];

    // index 0: 2 stages, depth 2; index 1: 3 stages, depth 4; index 2: pass-through, depth 4
    noc_pipeline_link #(.NUM_PIPELINE(2), .DOWNSTREAM_DEPTH(2)) u_p2 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
        .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(co[0]),
        .data_out(dout[0]), .dest_out(deo[0]), .is_tail_out(to[0]), .send_out(so[0]),
        .credit_in(credit_in), .err_clear(err_clear), .in_flight(if_p2),
        .flit_count(fc[0]), .pkt_count(pc[0]), .err(er[0]));

    noc_pipeline_link #(.NUM_PIPELINE(3), .DOWNSTREAM_DEPTH(4)) u_p3 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
        .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(co[1]),
        .data_out(dout[1]), .dest_out(deo[1]), .is_tail_out(to[1]), .send_out(so[1]),
        .credit_in(credit_in), .err_clear(err_clear), .in_flight(if_p3),
        .flit_count(fc[1]), .pkt_count(pc[1]), .err(er[1]));

    noc_pipeline_link #(.NUM_PIPELINE(0), .DOWNSTREAM_DEPTH(4)) u_p0 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
        .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(co[2]),
        .data_out(dout[2]), .dest_out(deo[2]), .is_tail_out(to[2]), .send_out(so[2]),
        .credit_in(credit_in), .err_clear(err_clear), .in_flight(if_p0),
        .flit_count(fc[2]), .pkt_count(pc[2]), .err(er[2]));

    function automatic int lat(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 3 : 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop due flits/credits and compare against what each instance presents this cycle.
    task automatic scoreboard();
        flit_t f;
        logic  ev;
        for (int i = 0; i < 3; i++) begin
            ev = 1'b0;
            if (fq[i].size() > 0) ev = (fq[i][0].due == cyc);
            chk($sformatf("send_out[%0d]@%0d", i, cyc), 32'(so[i]), 32'(ev));
            if (ev) begin
                f = fq[i].pop_front();
                if (so[i] === 1'b1) begin
                    chk($sformatf("data_out[%0d]@%0d", i, cyc), dout[i], f.data);
                    chk($sformatf("dest_out[%0d]@%0d", i, cyc), 32'(deo[i]), 32'(f.dest));
                    chk($sformatf("is_tail_out[%0d]@%0d", i, cyc), 32'(to[i]), 32'(f.tail));
                end
            end
            ev = 1'b0;
            if (cq[i].size() > 0) ev = (cq[i][0] == cyc);
            chk($sformatf("credit_out[%0d]@%0d", i, cyc), 32'(co[i]), 32'(ev));
            if (ev) void'(cq[i].pop_front());
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (sb_on) scoreboard();
        @(posedge clk);
        #1;
        cyc++;
        send_in    = 1'b0;
        credit_in  = 1'b0;
        err_clear  = 1'b0;
        is_tail_in = 1'b0;
        data_in    = '0;
        dest_in    = '0;
    endtask

    task automatic drive_flit(input logic [FW-1:0] d, input logic [DW-1:0] de, input logic t);
        flit_t f;
        send_in    = 1'b1;
        data_in    = d;
        dest_in    = de;
        is_tail_in = t;
        for (int i = 0; i < 3; i++) begin
            f.due  = cyc + lat(i);
            f.data = d;
            f.dest = de;
            f.tail = t;
            fq[i].push_back(f);
        end
    endtask

    task automatic drive_credit();
        credit_in = 1'b1;
        for (int i = 0; i < 3; i++) cq[i].push_back(cyc + lat(i));
    endtask

    // Reset discards everything not already at the outputs this cycle.
    task automatic flush();
        flit_t kf[$];
        int    kc[$];
        for (int i = 0; i < 3; i++) begin
            kf.delete();
            kc.delete();
            for (int j = 0; j < fq[i].size(); j++) if (fq[i][j].due <= cyc) kf.push_back(fq[i][j]);
            for (int j = 0; j < cq[i].size(); j++) if (cq[i][j] <= cyc) kc.push_back(cq[i][j]);
            fq[i] = kf;
            cq[i] = kc;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        flush();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic zero_chk(input int i, input string pre);
        chk({pre, "_send_out"},   32'(so[i]),  0);
        chk({pre, "_credit_out"}, 32'(co[i]),  0);
        chk({pre, "_data_out"},   dout[i],     0);
        chk({pre, "_dest_out"},   32'(deo[i]), 0);
        chk({pre, "_tail_out"},   32'(to[i]),  0);
        chk({pre, "_flit_count"}, 32'(fc[i]),  0);
        chk({pre, "_pkt_count"},  32'(pc[i]),  0);
        chk({pre, "_err"},        32'(er[i]),  0);
    endtask

    initial begin
        int exp_if;
        rst_n = 1'b0; send_in = 1'b0; credit_in = 1'b0; err_clear = 1'b0;
        is_tail_in = 1'b0; data_in = '0; dest_in = '0;
        cyc = 0; checks = 0; failures = 0; sb_on = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        sb_on = 1'b1;
        for (int i = 0; i < 3; i++) zero_chk(i, $sformatf("reset%0d", i));
        chk("reset_if_p2", 32'(if_p2), 0);
        chk("reset_if_p3", 32'(if_p3), 0);
        chk("reset_if_p0", 32'(if_p0), 0);

        // Three flits back to back; the depth-2 link overflows on the third.
        drive_flit(32'hA1, 6'h01, 1'b1); cycle();
        drive_flit(32'hA2, 6'h01, 1'b1); cycle();
        drive_flit(32'hA3, 6'h01, 1'b1); cycle();
        chk("ovf_err_p2",  32'(er[0]), 32'h1);
        chk("ovf_if_p2",   32'(if_p2), 2);
        chk("ovf_err_p3",  32'(er[1]), 0);
        chk("ovf_if_p3",   32'(if_p3), 3);
        chk("ovf_if_p0",   32'(if_p0), 3);
        chk("ovf_flits_p2", 32'(fc[0]), 3);
        chk("ovf_pkts_p2",  32'(pc[0]), 3);
        err_clear = 1'b1;
        drive_credit();
        cycle();
        chk("clr_err_p2", 32'(er[0]), 0);
        chk("crd_if_p0",  32'(if_p0), 2);
        cycle(); cycle();
        chk("crd_if_p2",  32'(if_p2), 1);
        cycle();
        chk("crd_if_p3",  32'(if_p3), 2);

        // Credit with nothing in flight: underflow after the credit delay plus one.
        apply_reset();
        drive_credit(); cycle();
        chk("unf_err_p0",  32'(er[2]), 32'h2);
        chk("unf_if_p0",   32'(if_p0), 0);
        cycle();
        chk("unf_early_p2", 32'(er[0]), 0);
        cycle();
        chk("unf_err_p2",   32'(er[0]), 32'h2);
        chk("unf_if_p2",    32'(if_p2), 0);
        chk("unf_early_p3", 32'(er[1]), 0);
        cycle();
        chk("unf_err_p3",   32'(er[1]), 32'h2);
        err_clear = 1'b1;
        drive_credit();
        cycle();
        chk("setwins_err_p0", 32'(er[2]), 32'h2);
        chk("clr2_err_p2",    32'(er[0]), 0);
        chk("clr2_err_p3",    32'(er[1]), 0);
        cycle(); cycle();
        chk("unf2_err_p2",    32'(er[0]), 32'h2);
        cycle();
        err_clear = 1'b1;
        cycle();
        for (int i = 0; i < 3; i++) chk($sformatf("clr3_err%0d", i), 32'(er[i]), 0);
        drive_flit(32'h5A5A_0001, 6'h02, 1'b1);
        drive_credit();
        cycle();
        chk("sendcrd_err_p0",  32'(er[2]), 32'h2);
        chk("sendcrd_if_p0",   32'(if_p0), 0);
        chk("sendcrd_flit_p0", 32'(fc[2]), 1);
        chk("sendcrd_if_p2",   32'(if_p2), 1);
        chk("sendcrd_err_p2",  32'(er[0]), 0);

        // Clean 3-flit packet then a single-flit packet to another dest.
        apply_reset();
        drive_flit(32'hC1, 6'h05, 1'b0); cycle();
        drive_flit(32'hC2, 6'h05, 1'b0); cycle();
        drive_flit(32'hC3, 6'h05, 1'b1); cycle();
        chk("pkt1_pkts_p3",  32'(pc[1]), 1);
        chk("pkt1_flits_p3", 32'(fc[1]), 3);
        drive_flit(32'hC4, 6'h09, 1'b1); cycle();
        chk("pkt1_err_p3",   32'(er[1]), 0);
        chk("pkt1_err_p0",   32'(er[2]), 0);
        chk("pkt1_pkts2_p3", 32'(pc[1]), 2);
        chk("pkt1_flits2_p3", 32'(fc[1]), 4);
        chk("pkt1_if_full_p3", 32'(if_p3), 4);

        // Body flit with a different dest flags err[2]; the tail still closes the packet.
        apply_reset();
        drive_flit(32'hD1, 6'h05, 1'b0); cycle();
        drive_flit(32'hD2, 6'h06, 1'b0); cycle();
        chk("pkt2_err_p0",   32'(er[2]), 32'h4);
        drive_flit(32'hD3, 6'h05, 1'b1); cycle();
        chk("pkt2_pkts_p0",  32'(pc[2]), 1);
        chk("pkt2_flits_p0", 32'(fc[2]), 3);
        drive_flit(32'hD4, 6'h07, 1'b1);
        drive_credit();
        cycle();
        chk("pkt2_sticky_p0", 32'(er[2]), 32'h4);
        chk("pkt2_pkts2_p0",  32'(pc[2]), 2);
        err_clear = 1'b1;
        drive_flit(32'hD5, 6'h08, 1'b1);
        cycle();
        chk("pkt2_idle_err_p0", 32'(er[2]), 0);
        chk("pkt2_pkts3_p0",    32'(pc[2]), 3);
        chk("pkt2_if_p0",       32'(if_p0), 4);

        // Eight single-flit packets back to back, each credited four cycles later.
        apply_reset();
        chk("b2b_if0_p0", 32'(if_p0), 0);
        for (int k = 0; k < 12; k++) begin
            if (k < 8) drive_flit(32'(32'hE0 + k), 6'(k), 1'b1);
            if (k >= 4) drive_credit();
            cycle();
            exp_if = ((k + 1) < 8 ? (k + 1) : 8) - ((k + 1) > 4 ? ((k - 3) < 8 ? (k - 3) : 8) : 0);
            chk($sformatf("b2b_if_p0_k%0d", k), 32'(if_p0), 32'(exp_if));
        end
        chk("b2b_pkts_p0",  32'(pc[2]), 8);
        chk("b2b_flits_p0", 32'(fc[2]), 8);
        chk("b2b_err_p0",   32'(er[2]), 0);

        // Reset mid-packet with flits and a credit still inside the 3-stage pipe.
        apply_reset();
        drive_flit(32'hF1, 6'h03, 1'b0); cycle();
        drive_flit(32'hF2, 6'h03, 1'b0);
        drive_credit();
        cycle();
        apply_reset();
        zero_chk(1, "midrst_p3");
        chk("midrst_if_p3", 32'(if_p3), 0);
        for (int k = 0; k < 5; k++) cycle();
        drive_flit(32'hF3, 6'h09, 1'b1); cycle();
        chk("postrst_err_p3",   32'(er[1]), 0);
        chk("postrst_flits_p3", 32'(fc[1]), 1);
        for (int k = 0; k < 5; k++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_pipeline_link.md
# noc_pipeline_link

Credit-based, registered link stage between a router output port and the neighbouring router's input port, including the local port that feeds the AXI-S deserializer shim. It adds `NUM_PIPELINE` register stages on the forward flit path and the same number on the reverse credit path. It also runs a per-link monitor that checks credit-protocol and wormhole-packet rules and exposes flit and packet counters. Credit accounting does not depend on link depth, so the stage is transparent to routing and flow control; it only lengthens the credit round trip.

## Interface
Parameters:
- `NUM_PIPELINE`, 1: register stages per direction; 0 is a combinational pass-through, and the monitor still operates.
- `FLIT_WIDTH`, 32: flit payload width.
- `DEST_WIDTH`, 6: destination field width ({tid, tdest}).
- `DOWNSTREAM_DEPTH`, 1: flit buffer depth of the receiving input port, i.e. the maximum number of flits in flight.
- `CNT_WIDTH`, 16: width of the flit and packet counters.

Ports:
- `clk` in 1: NoC clock. This is the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `data_in` in FLIT_WIDTH: flit from the router output.
- `dest_in` in DEST_WIDTH: flit destination.
- `is_tail_in` in 1: last flit of the packet.
- `send_in` in 1: flit valid; a one-cycle pulse per flit.
- `credit_out` out 1: credit returned to the upstream router.
- `data_out` / `dest_out` / `is_tail_out` / `send_out` out: flit toward the downstream input port.
- `credit_in` in 1: credit pulse from the downstream input port.
- `err_clear` in 1: clears all sticky error bits.
- `in_flight` out $clog2(DOWNSTREAM_DEPTH+1): number of flits sent whose credit has not yet returned, measured at the upstream side.
- `flit_count` out CNT_WIDTH: flits accepted on `send_in`; wraps modulo 2^CNT_WIDTH.
- `pkt_count` out CNT_WIDTH: tail flits accepted; wraps.
- `err` out 3: sticky error bits. [0] credit overflow, [1] credit underflow, [2] destination change mid-packet.

## Operation
- **Forward path.** A shift chain of `NUM_PIPELINE` stages, each holding {valid, data, dest, tail}.
  - Stage 0 loads `send_in` and the payload every cycle. There is no stall; credits guarantee the receiver has space.
- **Credit path.** A separate 1-bit shift chain of `NUM_PIPELINE` stages from `credit_in` to `credit_out`.
  - Credits are never merged or dropped; a pulse in yields exactly one pulse out.
- **In-flight counter.** Next value = `in_flight` + `send_in` − `credit_out`.
  - If `in_flight` == `DOWNSTREAM_DEPTH` and the next value would exceed it, set err[0] and saturate at `DOWNSTREAM_DEPTH`.
  - If `credit_out` arrives with `in_flight` == 0 and no `send_in`, set err[1] and hold at 0.
  - If `credit_out` arrives with `in_flight` == 0 together with `send_in`, the counter stays at 0, err[1] is also set, and no increment occurs.
- **Packet FSM.** Two states, IDLE and IN_PKT.
  - IDLE → IN_PKT on `send_in` & !`is_tail_in`; the head `dest_in` is latched.
  - IN_PKT → IDLE on `send_in` & `is_tail_in`.
  - `send_in` & `is_tail_in` in IDLE is a single-flit packet; the FSM stays in IDLE.
  - In IN_PKT, `send_in` with `dest_in` ≠ latched dest sets err[2]. The flit is still forwarded unchanged and the FSM transitions normally.
- **Counters.** `flit_count` increments on every `send_in`. `pkt_count` increments on every `send_in` & `is_tail_in`.
- **Sticky errors.** Once set, an err bit stays set until `err_clear`. If `err_clear` and a new error event occur in the same cycle, the bit is set (set wins).

## Timing
- **Reset.** Every pipeline valid and credit stage resets to 0, and every pipeline payload stage resets to 0.
  - `send_out` = 0, `credit_out` = 0, `data_out`/`dest_out`/`is_tail_out` = 0.
  - `in_flight` = 0, counters = 0, `err` = 0, FSM = IDLE.
  - A reset mid-packet discards in-flight flits and credits. Upstream and downstream must be reset together.
- **Forward latency.** `send_in` at cycle t appears as `send_out` at t+`NUM_PIPELINE`, with its payload aligned. For `NUM_PIPELINE` = 0 the outputs equal the inputs in the same cycle.
- **Credit latency.** `credit_in` at t appears as `credit_out` at t+`NUM_PIPELINE`.
- **Throughput.** One flit and one credit per cycle in each direction with no bubbles.
- **Monitor outputs.** `in_flight`, the counters and `err` are registered and reflect an event at t from cycle t+1.
- **Minimum round trip.** The credit round trip seen upstream is 2×`NUM_PIPELINE` + downstream credit delay. Sustained full rate requires `DOWNSTREAM_DEPTH` ≥ that round trip; this is a configuration rule, not checked in hardware.

## Test plan
- `NUM_PIPELINE` = 2: send flits 0xA1, 0xA2, 0xA3 at cycles 10, 11, 12 → `send_out` at 12, 13, 14 with the same data. A credit_in pulse at 20 → `credit_out` at 22.
- `DOWNSTREAM_DEPTH` = 2: two sends, then a third before any credit → err[0] = 1 and `in_flight` = 2. Then `err_clear` → err[0] = 0.
- `credit_in` pulse with `in_flight` = 0 → err[1] = 1 after the pipeline delay plus 1; `in_flight` stays 0.
- 3-flit packet with dest 0x05 on all flits → `pkt_count` = 1, `flit_count` = 3, FSM back to IDLE. Repeat with body dest 0x06 → err[2] = 1.
- Back-to-back single-flit packets for 8 cycles, each credited 4 cycles later with `DOWNSTREAM_DEPTH` = 4 → `pkt_count` = 8, no errors, `in_flight` never exceeds 4.
- Assert `rst_n` low mid-packet with `NUM_PIPELINE` = 3 → on the next cycle all outputs are 0, and no stale `send_out` or `credit_out` appears after reset is released.
